// File: rtl/ws2812b_pixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_pixel_rx
// Description : Single-pixel receiver for a WS2812B-style self-clocked serial
//               chain. Decodes the first 24 bits of each frame into a pixel
//               word and forwards every later bit to the next pixel. It latches
//               the word on a long low gap. Bit value is taken from the
//               high-pulse length. A pulse that stays high too long aborts the
//               frame and raises a sticky error.
//
// Ports       : clk       - clock; all logic on its rising edge
//               rst_n     - asynchronous active-low reset
//               din       - serial stream from upstream driver / pixel
//               dout      - registered stream forwarded to the next pixel
//               rgb       - last latched 24-bit pixel word (bit 0 = first bit)
//               rgb_valid - one-cycle pulse when rgb updates
//               err       - sticky error (short frame or over-long high pulse)
//
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_pixel_rx #(
    parameter int T1_MIN    = 2,
    parameter int HIGH_MAX  = 8,
    parameter int RESET_LOW = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic        dout,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_MAX = (HIGH_MAX > RESET_LOW) ? HIGH_MAX : RESET_LOW;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_T1_MIN    = c_CW'(T1_MIN);
    localparam logic [c_CW-1:0] c_HIGH_MAX  = c_CW'(HIGH_MAX);
    localparam logic [c_CW-1:0] c_RESET_LOW = c_CW'(RESET_LOW);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_SAT   = {c_CW{1'b1}};

    localparam logic [4:0] c_BITS_FULL = 5'd24;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HIGH  = 2'd1;
    localparam logic [1:0] c_ST_LOW   = 2'd2;
    localparam logic [1:0] c_ST_ABORT = 2'd3;

    // ------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_din_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], din};
        end
    end

    assign w_din_s = r_sync[1];

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_hcnt;
    logic [c_CW-1:0] w_hcnt_nxt;
    logic [c_CW-1:0] r_lcnt;
    logic [c_CW-1:0] w_lcnt_nxt;
    logic [4:0]      r_bitcnt;
    logic [4:0]      w_bitcnt_nxt;
    logic [23:0]     r_sh;
    logic [23:0]     w_sh_nxt;
    logic [23:0]     r_rgb;
    logic [23:0]     w_rgb_nxt;
    logic            r_rgb_valid;
    logic            w_rgb_valid_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            r_dout;
    logic            w_dout_nxt;

    // Saturating increments: the counters park at all-ones instead of wrapping,
    // so a stuck line can never be mistaken for a fresh short pulse or gap.
    logic [c_CW-1:0] w_hcnt_inc;
    logic [c_CW-1:0] w_lcnt_inc;
    logic            w_hcnt_over;
    logic            w_lcnt_gap;
    logic            w_bit;

    assign w_hcnt_inc  = (r_hcnt == c_CNT_SAT) ? r_hcnt : r_hcnt + c_CNT_ONE;
    assign w_lcnt_inc  = (r_lcnt == c_CNT_SAT) ? r_lcnt : r_lcnt + c_CNT_ONE;
    assign w_hcnt_over = (w_hcnt_inc >= c_HIGH_MAX);
    assign w_lcnt_gap  = (w_lcnt_inc >= c_RESET_LOW);
    // Decoded once the falling edge is seen in HIGH, so hcnt is the full length.
    assign w_bit       = (r_hcnt >= c_T1_MIN);

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_din_s) begin
                    w_state_nxt = c_ST_HIGH;
                end
            end
            c_ST_HIGH: begin
                if (w_din_s) begin
                    if (w_hcnt_over) begin
                        w_state_nxt = c_ST_ABORT;
                    end
                end else begin
                    w_state_nxt = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (w_din_s) begin
                    w_state_nxt = c_ST_HIGH;
                end else if (w_lcnt_gap) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_ABORT: begin
                if (!w_din_s && w_lcnt_gap) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: datapath / output next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_hcnt_nxt      = r_hcnt;
        w_lcnt_nxt      = r_lcnt;
        w_bitcnt_nxt    = r_bitcnt;
        w_sh_nxt        = r_sh;
        w_rgb_nxt       = r_rgb;
        w_rgb_valid_nxt = 1'b0;
        w_err_nxt       = r_err;

        case (r_state)
            c_ST_IDLE: begin
                if (w_din_s) begin
                    w_hcnt_nxt = c_CNT_ONE;
                end
            end
            c_ST_HIGH: begin
                if (w_din_s) begin
                    w_hcnt_nxt = w_hcnt_inc;
                    if (w_hcnt_over) begin
                        w_err_nxt  = 1'b1;
                        w_lcnt_nxt = '0;
                    end
                end else begin
                    // Bits past the 24th belong to downstream pixels.
                    if (r_bitcnt < c_BITS_FULL) begin
                        w_sh_nxt     = {w_bit, r_sh[23:1]};
                        w_bitcnt_nxt = r_bitcnt + 5'd1;
                    end
                    w_lcnt_nxt = c_CNT_ONE;
                end
            end
            c_ST_LOW: begin
                if (w_din_s) begin
                    w_hcnt_nxt = c_CNT_ONE;
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                    if (w_lcnt_gap) begin
                        if (r_bitcnt == c_BITS_FULL) begin
                            w_rgb_nxt       = r_sh;
                            w_rgb_valid_nxt = 1'b1;
                            w_err_nxt       = 1'b0;
                        end else if (r_bitcnt != 5'd0) begin
                            w_err_nxt = 1'b1;
                        end
                        w_bitcnt_nxt = 5'd0;
                    end
                end
            end
            c_ST_ABORT: begin
                // Only a clean RESET_LOW gap resynchronises after an abort.
                if (w_din_s) begin
                    w_lcnt_nxt = '0;
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                    if (w_lcnt_gap) begin
                        w_bitcnt_nxt = 5'd0;
                    end
                end
            end
            default: begin
                w_bitcnt_nxt = 5'd0;
            end
        endcase
    end

    // Forwarding gate: opens once our 24 bits are in and stays open until the
    // latch gap returns bitcnt to zero. Both edges fall in a low period, so no
    // partial pulse ever reaches dout.
    assign w_dout_nxt = ((r_bitcnt == c_BITS_FULL) && (r_state != c_ST_ABORT)) ? w_din_s : 1'b0;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt      <= '0;
            r_lcnt      <= '0;
            r_bitcnt    <= 5'd0;
            r_sh        <= 24'h000000;
            r_rgb       <= 24'h000000;
            r_rgb_valid <= 1'b0;
            r_err       <= 1'b0;
            r_dout      <= 1'b0;
        end else begin
            r_hcnt      <= w_hcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_sh        <= w_sh_nxt;
            r_rgb       <= w_rgb_nxt;
            r_rgb_valid <= w_rgb_valid_nxt;
            r_err       <= w_err_nxt;
            r_dout      <= w_dout_nxt;
        end
    end

    assign dout      = r_dout;
    assign rgb       = r_rgb;
    assign rgb_valid = r_rgb_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_pixel_rx
// Description : Directed self-checking bench for ws2812b_pixel_rx. Drives
//               hand-built WS2812B waveforms ('0' = 1 high + 2 low,
//               '1' = 2 high + 1 low) and checks the latched word, the
//               rgb_valid pulses, the sticky error and the forwarded stream.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812b_pixel_rx;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        dout;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    // Per-cycle logs: din_log[k] is din seen at posedge k, dout_log[k] is dout
    // just after posedge k.
    logic din_log  [0:4095];
    logic dout_log [0:4095];
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_rise   = 0;
    logic dout_prev = 1'b0;

    ws2812b_pixel_rx #(
        .T1_MIN    (2),
        .HIGH_MAX  (8),
        .RESET_LOW (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .dout      (dout),
        .rgb       (rgb),
        .rgb_valid (rgb_valid),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (cyc < 4096) din_log[cyc] <= din;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= 4096) dout_log[cyc-1] <= dout;
        if (rgb_valid) n_valid <= n_valid + 1;
        if (dout && !dout_prev) n_rise <= n_rise + 1;
        dout_prev <= dout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 2);
            drive(1'b0, 1);
        end else begin
            drive(1'b1, 1);
            drive(1'b0, 2);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic gap();
        drive(1'b0, 64);
        drive(1'b0, 4);
    endtask

    int v0;
    int r0;
    int s_idx;
    int e_idx;
    int f0;
    int mism;
    logic [23:0] w_c0;
    logic        exp_d;

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rgb",   {8'h0, rgb}, 32'h0);
        check("reset_valid", {31'h0, rgb_valid}, 32'h0);
        check("reset_err",   {31'h0, err}, 32'h0);
        check("reset_dout",  {31'h0, dout}, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 3);

        // Single 24-bit frame: latch, one pulse, nothing forwarded.
        v0 = n_valid; r0 = n_rise;
        send_bits(24'hA5C3F0, 24);
        gap();
        check("f1_rgb",   {8'h0, rgb}, 32'h00A5C3F0);
        check("f1_valid", n_valid - v0, 1);
        check("f1_rise",  n_rise - r0, 0);
        check("f1_err",   {31'h0, err}, 32'h0);

        // 48 bits: first word latched, second forwarded with fixed latency.
        v0 = n_valid; r0 = n_rise;
        f0 = cyc;
        send_bits(24'h123456, 24);
        s_idx = cyc;
        send_bits(24'hFEDCBA, 24);
        gap();
        e_idx = cyc;
        drive(1'b0, 3);
        check("f2_rgb",   {8'h0, rgb}, 32'h00123456);
        check("f2_valid", n_valid - v0, 1);
        mism = 0;
        for (int k = f0; k < e_idx; k++) begin
            exp_d = ((k - 2 >= s_idx) && (k - 2 < e_idx)) ? din_log[k-2] : 1'b0;
            if (dout_log[k] !== exp_d) mism++;
        end
        check("f2_dout_wave", mism, 0);
        check("f2_rise", n_rise - r0, 24);

        // Short frame: error, rgb untouched; then a good frame clears it.
        v0 = n_valid;
        send_bits(24'h3FF, 10);
        gap();
        check("short_err",   {31'h0, err}, 32'h1);
        check("short_rgb",   {8'h0, rgb}, 32'h00123456);
        check("short_valid", n_valid - v0, 0);
        send_bits(24'h00FF00, 24);
        gap();
        check("recover_rgb", {8'h0, rgb}, 32'h0000FF00);
        check("recover_err", {31'h0, err}, 32'h0);

        // Over-long high pulse mid-frame: abort, ignore bits until a gap.
        v0 = n_valid;
        send_bits(24'h15, 5);
        drive(1'b1, 8);
        drive(1'b0, 6);
        check("abort_err", {31'h0, err}, 32'h1);
        send_bits(24'h3F, 6);
        gap();
        check("abort_valid", n_valid - v0, 0);
        check("abort_rgb",   {8'h0, rgb}, 32'h0000FF00);
        send_bits(24'h5A5A5A, 24);
        gap();
        check("post_abort_rgb", {8'h0, rgb}, 32'h005A5A5A);
        check("post_abort_err", {31'h0, err}, 32'h0);

        // 63-cycle low run after bit 12 must not latch.
        v0 = n_valid;
        w_c0 = 24'hC0FFEE;
        send_bits(w_c0, 11);
        if (w_c0[11]) drive(1'b1, 2); else drive(1'b1, 1);
        drive(1'b0, 63);
        for (int i = 12; i < 24; i++) send_bit(w_c0[i]);
        drive(1'b0, 1);
        check("gap63_valid_mid", n_valid - v0, 0);
        gap();
        check("gap63_valid", n_valid - v0, 1);
        check("gap63_rgb",   {8'h0, rgb}, 32'h00C0FFEE);
        check("gap63_err",   {31'h0, err}, 32'h0);

        // Mid-frame reset clears everything at once.
        send_bits(24'h7, 3);
        gap();
        check("pre_rst_err", {31'h0, err}, 32'h1);
        send_bits(24'h0F0F0F, 20);
        rst_n = 1'b0;
        #1;
        check("rst_rgb",   {8'h0, rgb}, 32'h0);
        check("rst_err",   {31'h0, err}, 32'h0);
        check("rst_valid", {31'h0, rgb_valid}, 32'h0);
        check("rst_dout",  {31'h0, dout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2);
        v0 = n_valid;
        send_bits(24'hFFFFFF, 24);
        gap();
        check("post_rst_rgb",   {8'h0, rgb}, 32'h00FFFFFF);
        check("post_rst_valid", n_valid - v0, 1);
        check("post_rst_err",   {31'h0, err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812b_pixel_rx.md
WS2812B_PIXEL_RX -- requirements
Module: ws2812b_pixel_rx

Interface
REQ-001 SHALL provide parameter T1_MIN, default 2: minimum high-pulse length in clk cycles that is decoded as bit '1'; shorter pulses decode as '0'.
REQ-002 SHALL provide parameter HIGH_MAX, default 8: high-pulse length in clk cycles that marks the pulse as illegal.
REQ-003 SHALL provide parameter RESET_LOW, default 64: number of consecutive low cycles that marks a latch/reset gap.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port din, input, 1: serial WS2812B-style stream from the upstream tape driver or the previous pixel.
REQ-007 SHALL have port dout, output, 1: stream forwarded to the next pixel.
REQ-008 SHALL have port rgb, output, 24: last latched pixel word.
REQ-009 SHALL have port rgb_valid, output, 1: one-cycle pulse when rgb updates.
REQ-010 SHALL have port err, output, 1: sticky error flag.

Function
REQ-011 SHALL pass din through a 2-flop synchronizer; din_s below denotes the synchronizer output.
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW and ABORT, with state evaluated on din_s.
REQ-013 IDLE: when din_s=1, SHALL go to HIGH with hcnt=1; otherwise SHALL stay in IDLE.
REQ-014 HIGH, din_s=1: SHALL increment hcnt; on reaching HIGH_MAX SHALL set err, zero lcnt and go to ABORT.
REQ-015 HIGH, din_s=0: SHALL decode bit = (hcnt >= T1_MIN).
- If bitcnt < 24: SHALL shift the bit in at the MSB (sh <= {bit, sh[23:1]}) and increment bitcnt.
- If bitcnt = 24: SHALL discard the bit, because it belongs to a downstream pixel.
- In both cases: SHALL go to LOW with lcnt=1.
REQ-016 LOW, din_s=1: SHALL go to HIGH with hcnt=1.
REQ-017 LOW, din_s=0: SHALL increment lcnt; when lcnt reaches RESET_LOW:
- bitcnt=24: rgb <= sh, rgb_valid=1 for exactly one cycle, err cleared.
- bitcnt in 1..23: set err, leave rgb unchanged.
- bitcnt=0: no action.
- In all cases: bitcnt <= 0, go to IDLE.
REQ-018 ABORT: SHALL ignore bits; SHALL count consecutive low cycles (lcnt resets to 0 on din_s=1); at RESET_LOW SHALL set bitcnt <= 0 and go to IDLE without latching.
REQ-019 Bit order: the first received bit SHALL land in rgb[0] and the 24th in rgb[23].
REQ-020 hcnt and lcnt SHALL saturate and never wrap; width SHALL be clog2(max(HIGH_MAX, RESET_LOW)+1).
REQ-021 dout SHALL be registered: dout <= (bitcnt==24 && state!=ABORT) ? din_s : 0. Latency din->dout is 3 clk cycles when passing.
REQ-022 The gate SHALL open from the cycle after the 24th bit's falling edge is decoded, so the first forwarded rising edge is bit 25's and no partial pulse is emitted.
REQ-023 The gate SHALL close in the cycle bitcnt returns to 0, which is after RESET_LOW low cycles, so dout is already low when it closes.
REQ-024 A gap shorter than RESET_LOW SHALL NOT latch; the next high pulse continues the current frame.
REQ-025 A new frame SHALL be able to start in the cycle immediately following IDLE entry.
REQ-026 rgb_valid and err SHALL change only on RESET_LOW detection or on a HIGH_MAX violation, never both in the same cycle.

Reset
REQ-027 While rst_n=0, all of the following SHALL hold immediately (asynchronous):
- state=IDLE, synchronizer=0, hcnt=lcnt=bitcnt=0, sh=0.
- rgb=24'h000000, rgb_valid=0, err=0, dout=0.
REQ-028 Asserting reset mid-frame SHALL discard partial data; after release, decoding SHALL start at the next rising edge of din_s.

Verification
REQ-029 Send 24 bits encoding 24'hA5C3F0 (bit0 first; '0' = 1 high + 2 low, '1' = 2 high + 1 low), then 64 low -> rgb=24'hA5C3F0, single rgb_valid pulse, dout stays 0 throughout.
REQ-030 Send 48 bits (first word 24'h123456, second 24'hFEDCBA), then reset gap -> rgb=24'h123456; dout reproduces exactly the second 24-bit waveform delayed 3 cycles.
REQ-031 Send 10 bits, then 64 low -> err=1, rgb unchanged, no rgb_valid; then send a valid frame 24'h00FF00 -> rgb=24'h00FF00, err=0.
REQ-032 Hold din high for 8 cycles mid-frame -> err=1, state ABORT, no bits shifted; after 64 low, the next valid frame latches normally.
REQ-033 Insert a 63-cycle low gap after bit 12, then send the remaining 12 bits and a 64-cycle gap -> one latch with all 24 bits intact.
REQ-034 Assert rst_n=0 for 1 cycle after bit 20 -> all outputs 0 at once; a following full frame 24'hFFFFFF latches correctly.
